// File: rtl/mplier_pkg.sv
// Shared definitions for the radix-8 Booth multiplier: the recode digit
// type, its encodings, and the partial-product count helper.
package mplier_pkg;

  // One radix-8 Booth digit, -4..+4 in 4-bit two's complement.
  typedef logic signed [3:0] booth_digit_t;

  localparam booth_digit_t ZERO = 4'sd0;
  localparam booth_digit_t P1   = 4'sd1;
  localparam booth_digit_t P2   = 4'sd2;
  localparam booth_digit_t P3   = 4'sd3;
  localparam booth_digit_t P4   = 4'sd4;
  localparam booth_digit_t M1   = -4'sd1;
  localparam booth_digit_t M2   = -4'sd2;
  localparam booth_digit_t M3   = -4'sd3;
  localparam booth_digit_t M4   = -4'sd4;

  // Number of partial products. A signed multiplier needs one sign bit of
  // headroom; an unsigned one needs the extra zero bit above its MSB as well,
  // so the top digit can never come out negative.
  function automatic int npp(input int width, input bit unsigned_en);
    return unsigned_en ? (width + 4) / 3 : (width + 3) / 3;
  endfunction

endpackage

// File: rtl/booth8_pp_sel.sv
// Radix-8 Booth digit recoder and partial-product selector (combinational).
// Produces digit * mcand as a WIDTH+3 bit two's complement value.
module booth8_pp_sel #(
  parameter int WIDTH = 16
) (
  input  logic [3:0]       i_win,
  input  logic [WIDTH-1:0] i_mcand,
  input  logic [WIDTH+1:0] i_mcand3x,
  input  logic             i_signed,
  output logic [WIDTH+2:0] o_pp
);
  import mplier_pkg::*;

  localparam int PPW = WIDTH + 3;

  booth_digit_t     w_digit;
  logic             w_mc_sx;
  logic [PPW-1:0]   w_m1;
  logic [PPW-1:0]   w_m3;
  logic [PPW-1:0]   w_mag;

  // Window {b3,b2,b1,b0} has value -4*b3 + 2*b2 + b1 + b0.
  assign w_digit = booth_digit_t'({i_win[3], i_win[3:1]}) + booth_digit_t'({3'b000, i_win[0]});

  assign w_mc_sx = i_signed & i_mcand[WIDTH-1];
  assign w_m1    = {{3{w_mc_sx}}, i_mcand};
  assign w_m3    = {(i_signed & i_mcand3x[WIDTH+1]), i_mcand3x};

  // Select the digit magnitude times mcand; unused codes give zero.
  always_comb begin
    w_mag = '0;
    case (w_digit)
      P1, M1:  w_mag = w_m1;
      P2, M2:  w_mag = w_m1 << 1;
      P3, M3:  w_mag = w_m3;
      P4, M4:  w_mag = w_m1 << 2;
      default: w_mag = '0;
    endcase
  end

  // Negative digits negate the selected multiple.
  assign o_pp = w_digit[3] ? (~w_mag + PPW'(1)) : w_mag;

endmodule

// File: rtl/booth8_mult_pipe.sv
// Three-stage pipelined radix-8 Booth multiplier with valid/ready on both
// sides. S1: recode, 3x, select. S2: carry-save compression. S3: final add.
// Optional macro MPLIER_UNSIGNED_EN adds the in_signed port so operands can
// be treated as unsigned.
module booth8_mult_pipe #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
`ifdef MPLIER_UNSIGNED_EN
  input  logic               in_signed,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);
  import mplier_pkg::*;

`ifdef MPLIER_UNSIGNED_EN
  localparam bit UNS_EN = 1'b1;
`else
  localparam bit UNS_EN = 1'b0;
`endif
  localparam int NPP  = npp(WIDTH, UNS_EN);
  localparam int PPW  = WIDTH + 3;
  localparam int PW   = 2 * WIDTH;
  localparam int MEXT = 3 * NPP + 1;

  logic              w_adv;
  logic              w_sgn;
  logic [MEXT-1:0]   w_mext;
  logic [WIDTH+1:0]  w_mc_ext2;
  logic [WIDTH+1:0]  w_mcand3x;
  logic [PPW-1:0]    w_pp   [NPP];
  logic [PW-1:0]     w_row  [NPP];
  logic [PW-1:0]     w_s    [NPP];
  logic [PW-1:0]     w_c    [NPP];

  logic              r_v1, r_v2, r_v3;
  logic [PPW-1:0]    r_pp   [NPP];
  logic [PW-1:0]     r_sum, r_carry;
  logic [PW-1:0]     r_prod;

`ifdef MPLIER_UNSIGNED_EN
  assign w_sgn = in_signed;
`else
  assign w_sgn = 1'b1;
`endif

  // The whole pipe moves together; it only stalls when a finished product
  // is waiting and the consumer is not taking it.
  assign w_adv     = !r_v3 || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_v3;
  assign product   = r_prod;

  // ---------------- S1: recode, 3x, partial-product select ----------------
  assign w_mext    = {{(MEXT-WIDTH-1){w_sgn & mplier[WIDTH-1]}}, mplier, 1'b0};
  assign w_mc_ext2 = {{2{w_sgn & mcand[WIDTH-1]}}, mcand};
  assign w_mcand3x = w_mc_ext2 + {w_mc_ext2[WIDTH:0], 1'b0};

  genvar gi;
  generate
    for (gi = 0; gi < NPP; gi++) begin : g_sel
      booth8_pp_sel #(.WIDTH(WIDTH)) u_sel (
        .i_win     (w_mext[3*gi+3 -: 4]),
        .i_mcand   (mcand),
        .i_mcand3x (w_mcand3x),
        .i_signed  (w_sgn),
        .o_pp      (w_pp[gi])
      );
    end
  endgenerate

  // S1 data register: partial products of the accepted operand pair.
  always_ff @(posedge clk) begin
    if (w_adv) r_pp <= w_pp;
  end

  // ---------------- S2: carry-save compression ----------------------------
  // Each partial product is sign-extended to full width and weighted by 8^i,
  // then folded into a running sum/carry pair with per-column 3:2 counters.
  generate
    for (gi = 0; gi < NPP; gi++) begin : g_row
      assign w_row[gi] = {{(PW-PPW){r_pp[gi][PPW-1]}}, r_pp[gi]} << (3*gi);
    end
  endgenerate

  assign w_s[0] = w_row[0];
  assign w_c[0] = '0;
  generate
    for (gi = 1; gi < NPP; gi++) begin : g_csa
      assign w_s[gi] = w_s[gi-1] ^ w_c[gi-1] ^ w_row[gi];
      assign w_c[gi] = ((w_s[gi-1] & w_c[gi-1]) | (w_s[gi-1] & w_row[gi]) |
                        (w_c[gi-1] & w_row[gi])) << 1;
    end
  endgenerate

  // S2 data register: redundant sum/carry rows.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_sum   <= w_s[NPP-1];
      r_carry <= w_c[NPP-1];
    end
  end

  // ---------------- S3: final carry-propagate add -------------------------
  // Product register; holds while stalled so the consumer sees a stable value.
  always_ff @(posedge clk) begin
    if (rst) r_prod <= '0;
    else if (w_adv) r_prod <= r_sum + r_carry;
  end

  // Stage valid bits shift with the data; bubbles enter as zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else if (w_adv) begin
      r_v1 <= in_valid;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
    end
  end

endmodule
